regfile_mp: RTL and testbench

- Parametrised multi-port integer register file for the NPC core; successor to the single-write, dual-read register file.
- Adds configurable width, depth and read/write port counts, write-to-read bypass, and a per-register busy scoreboard for pipeline hazard detection.
- Adds a post-reset clearing sweep so every architectural register reads as zero without async-reset flops on the storage array.
- Sits between decode (read ports, scoreboard alloc/query) and writeback (write ports).

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/rf_scoreboard.sv | 67 ++++++
 rtl/regfile_mp.sv | 148 ++++++++++++++
 tb/tb_regfile_mp.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the multi-port register file.
//   rf_state_e     : controller state (post-reset clearing sweep, then normal run).
//   rf_addr_width  : address width derived from the register count.
//   rf_lsb         : bit offset of port <port> inside a packed per-port bus.
package regfile_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  // Smallest register file we support; below this the address would be 0 bits.
  localparam int RF_MIN_REGS = 2;

  function automatic int rf_addr_width(input int nreg);
    return (nreg < RF_MIN_REGS) ? 1 : $clog2(nreg);
  endfunction

  function automatic int rf_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits for pipeline hazard detection.
// Ports:
//   clock, reset (async, active-low)
//   run        : high when the register file is out of its clearing sweep
//   wen/waddr  : writeback ports; an enabled write clears the target's busy bit
//   alloc_en/alloc_addr : marks a destination busy (new producer issued)
//   flush      : clears every busy bit (beats a same-cycle alloc)
//   raddr/busy : per read port lookup of the registered busy state
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  parameter int AW   = rf_addr_width(NREG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [NWR-1:0]    wen,
  input  logic [NWR*AW-1:0] waddr,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  input  logic              flush,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD-1:0]    busy
);

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  // Order matters: clears from writeback first, then the alloc set so a
  // new producer on the same register stays outstanding, then flush on top.
  always_comb begin
    busy_next = busy_reg;
    if (run) begin
      for (int j = 0; j < NWR; j++) begin
        if (wen[j]) begin
          busy_next[waddr[rf_lsb(j, AW) +: AW]] = 1'b0;
        end
      end
      if (alloc_en) begin
        busy_next[alloc_addr] = 1'b1;
      end
      if (flush) begin
        busy_next = '0;
      end
    end
    // x0 never has a pending producer.
    busy_next[0] = 1'b0;
  end

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_lookup
      assign busy[gi] = run & busy_reg[raddr[rf_lsb(gi, AW) +: AW]];
    end
  endgenerate

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
// Ports:
//   clock, reset (async, active-low)
//   io_raddr/io_rdata : NRD combinational read ports, packed AW / XLEN per port
//   io_wen/io_waddr/io_wdata : NWR write ports, highest index wins on collision
//   io_alloc_en/io_alloc_addr/io_flush : busy scoreboard control
//   io_busy  : registered busy bit of each read port's register
//   io_ready : high once every register has been cleared after reset
// The storage array has no reset; instead a sweep writes zero to one register
// per cycle after reset. During the sweep writes/allocs are ignored and all
// read outputs are forced to zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int NWR    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = rf_addr_width(NREG)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   io_raddr,
  output logic [NRD*XLEN-1:0] io_rdata,
  input  logic [NWR-1:0]      io_wen,
  input  logic [NWR*AW-1:0]   io_waddr,
  input  logic [NWR*XLEN-1:0] io_wdata,
  input  logic                io_alloc_en,
  input  logic [AW-1:0]       io_alloc_addr,
  input  logic                io_flush,
  output logic [NRD-1:0]      io_busy,
  output logic                io_ready
);

  rf_state_e       state_reg, state_next;
  logic [AW-1:0]   cnt_reg, cnt_next;
  logic            run;
  logic [XLEN-1:0] mem_reg [NREG];

  logic [AW-1:0]   wr_addr [NWR];
  logic [XLEN-1:0] wr_data [NWR];

  generate
    for (genvar gi = 0; gi < NWR; gi++) begin : g_wr_unpack
      assign wr_addr[gi] = io_waddr[rf_lsb(gi, AW) +: AW];
      assign wr_data[gi] = io_wdata[rf_lsb(gi, XLEN) +: XLEN];
    end
  endgenerate

  // ---------------- clearing-sweep controller ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= RF_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RF_INIT: begin
        cnt_next = cnt_reg + AW'(1);
        if (cnt_reg == AW'(NREG - 1)) begin
          state_next = RF_RUN;
          cnt_next   = '0;
        end
      end
      RF_RUN: begin
        state_next = RF_RUN;
      end
      default: begin
        state_next = RF_INIT;
        cnt_next   = '0;
      end
    endcase
  end

  assign run      = (state_reg == RF_RUN);
  assign io_ready = run;

  // ---------------- storage ----------------
  // Later loop iterations overwrite earlier ones, so the highest-indexed
  // enabled port wins when several target the same register.
  always_ff @(posedge clock) begin
    if (!run) begin
      mem_reg[cnt_reg] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (io_wen[j] && (wr_addr[j] != '0)) begin
          mem_reg[wr_addr[j]] <= wr_data[j];
        end
      end
    end
  end

  // ---------------- read ports with optional write-first bypass ----------------
  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   rd_addr;
      logic [XLEN-1:0] rd_val;

      assign rd_addr = io_raddr[rf_lsb(gi, AW) +: AW];

      always_comb begin
        rd_val = mem_reg[rd_addr];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (io_wen[j] && (wr_addr[j] == rd_addr)) begin
              rd_val = wr_data[j];
            end
          end
        end
        // x0 and the whole file during the sweep read as zero; this also
        // hides stale bypass data aimed at x0.
        if (!run || (rd_addr == '0)) begin
          rd_val = '0;
        end
      end

      assign io_rdata[rf_lsb(gi, XLEN) +: XLEN] = rd_val;
    end
  endgenerate

  // ---------------- busy scoreboard ----------------
  rf_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR),
    .AW   (AW)
  ) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .wen        (io_wen),
    .waddr      (io_waddr),
    .alloc_en   (io_alloc_en),
    .alloc_addr (io_alloc_addr),
    .flush      (io_flush),
    .raddr      (io_raddr),
    .busy       (io_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances share all inputs, one with write-first
// bypass and one without. A behavioural model (plain arrays) predicts reads
// and busy bits.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [2*AW-1:0]   io_raddr;
  logic [1:0]        io_wen;
  logic [2*AW-1:0]   io_waddr;
  logic [2*XLEN-1:0] io_wdata;
  logic              io_alloc_en;
  logic [AW-1:0]     io_alloc_addr;
  logic              io_flush;

  logic [2*XLEN-1:0] rdata_b, rdata_n;
  logic [1:0]        busy_b, busy_n;
  logic              ready_b, ready_n;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [XLEN-1:0] m_mem [NREG];
  bit              m_busy [NREG];
  bit              m_run;
  int              ra [2];

  always #5 clock = ~clock;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(2), .BYPASS(1)) dut_b (
    .clock(clock), .reset(reset), .io_raddr(io_raddr), .io_rdata(rdata_b),
    .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata),
    .io_alloc_en(io_alloc_en), .io_alloc_addr(io_alloc_addr), .io_flush(io_flush),
    .io_busy(busy_b), .io_ready(ready_b)
  );

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(2), .BYPASS(0)) dut_n (
    .clock(clock), .reset(reset), .io_raddr(io_raddr), .io_rdata(rdata_n),
    .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata),
    .io_alloc_en(io_alloc_en), .io_alloc_addr(io_alloc_addr), .io_flush(io_flush),
    .io_busy(busy_n), .io_ready(ready_n)
  );

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    io_wen = '0; io_waddr = '0; io_wdata = '0;
    io_alloc_en = 1'b0; io_alloc_addr = '0; io_flush = 1'b0;
  endtask

  task automatic set_read(input int a0, input int a1);
    ra[0] = a0; ra[1] = a1;
    io_raddr = {5'(a1), 5'(a0)};
  endtask

  task automatic set_write(input int j, input int a, input logic [31:0] d);
    io_wen[j] = 1'b1;
    io_waddr[j*AW +: AW] = 5'(a);
    io_wdata[j*XLEN +: XLEN] = d;
  endtask

  // Expected read: stored value, or (write-first) the highest enabled port
  // writing the same nonzero register this cycle; x0 and the sweep read 0.
  function automatic logic [31:0] exp_read(input int a, input bit byp);
    logic [31:0] r;
    if (!m_run || a == 0) return 32'h0;
    r = m_mem[a];
    if (byp)
      for (int j = 0; j < 2; j++)
        if (io_wen[j] && int'(io_waddr[j*AW +: AW]) == a) r = io_wdata[j*XLEN +: XLEN];
    return r;
  endfunction

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clock);
    if (m_run) begin
      if (io_flush) begin
        for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
      end else begin
        for (int j = 0; j < 2; j++)
          if (io_wen[j]) m_busy[io_waddr[j*AW +: AW]] = 1'b0;
        if (io_alloc_en && io_alloc_addr != 0) m_busy[io_alloc_addr] = 1'b1;
      end
      for (int j = 0; j < 2; j++)
        if (io_wen[j] && io_waddr[j*AW +: AW] != 0)
          m_mem[io_waddr[j*AW +: AW]] = io_wdata[j*XLEN +: XLEN];
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] got;
    reset = 1'b0; set_idle(); set_read(0, 0);
    m_run = 1'b0;
    for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (ready_b !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready_b); end
    n_cmp++; if (busy_b !== 2'b00) begin n_fail++; $display("FAIL reset_busy: got %b want 00", busy_b); end
    @(negedge clock) reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock); #1;
      n_cmp++; if (ready_b !== 1'b0) begin n_fail++; $display("FAIL sweep1_ready k=%0d: got %b want 0", k, ready_b); end
    end
    // Reassert mid-sweep: the sweep must start over.
    @(negedge clock) reset = 1'b0;
    #1;
    n_cmp++; if (ready_b !== 1'b0) begin n_fail++; $display("FAIL midreset_ready: got %b want 0", ready_b); end
    @(negedge clock) reset = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clock); #1;
      n_cmp++; if (ready_b !== (k == 32)) begin n_fail++; $display("FAIL sweep2_ready_b k=%0d: got %b want %b", k, ready_b, k == 32); end
      n_cmp++; if (ready_n !== (k == 32)) begin n_fail++; $display("FAIL sweep2_ready_n k=%0d: got %b want %b", k, ready_n, k == 32); end
      if (k < 32) begin
        // Traffic during the sweep must be ignored and reads forced to zero.
        io_wen = 2'($urandom_range(0, 3));
        io_waddr = 10'($urandom); io_wdata = {$urandom, $urandom};
        io_alloc_en = 1'b1; io_alloc_addr = 5'($urandom_range(1, 31));
        set_read($urandom_range(0, 31), $urandom_range(0, 31));
        #1;
        n_cmp++; if (rdata_b !== 64'h0) begin n_fail++; $display("FAIL init_rdata k=%0d: got %h want 0", k, rdata_b); end
        n_cmp++; if (busy_b !== 2'b00) begin n_fail++; $display("FAIL init_busy k=%0d: got %b want 00", k, busy_b); end
      end else begin
        set_idle();
      end
    end
    m_run = 1'b1;
    for (int r = 0; r < NREG; r++) begin m_mem[r] = '0; m_busy[r] = 1'b0; end
    for (int r = 0; r < NREG; r++) begin
      set_read(r, NREG - 1 - r);
      #1;
      for (int p = 0; p < 2; p++) begin
        got = rdata_b[p*XLEN +: XLEN];
        n_cmp++; if (got !== exp_read(ra[p], 1'b1)) begin n_fail++; $display("FAIL swept_zero r%0d: got %h want %h", ra[p], got, exp_read(ra[p], 1'b1)); end
      end
      n_cmp++; if (busy_b !== 2'b00) begin n_fail++; $display("FAIL swept_busy r%0d: got %b want 00", r, busy_b); end
    end
    $display("txn reset: sweep and mid-sweep reset done");
  endtask

  task automatic test_x0();
    set_idle();
    set_write(0, 0, 32'hDEADBEEF);
    io_alloc_en = 1'b1; io_alloc_addr = 5'd0;
    set_read(0, 0);
    #1;
    n_cmp++; if (rdata_b[31:0] !== 32'h0) begin n_fail++; $display("FAIL x0_same_cycle: got %h want 0", rdata_b[31:0]); end
    tick();
    set_idle(); set_read(0, 0);
    #1;
    n_cmp++; if (rdata_b[31:0] !== exp_read(0, 1'b1)) begin n_fail++; $display("FAIL x0_read: got %h want %h", rdata_b[31:0], exp_read(0, 1'b1)); end
    n_cmp++; if (busy_b[0] !== m_busy[0]) begin n_fail++; $display("FAIL x0_busy: got %b want %b", busy_b[0], m_busy[0]); end
    $display("txn x0: write DEADBEEF + alloc to x0");
  endtask

  task automatic test_collision();
    set_idle();
    set_write(0, 5, 32'h11111111);
    set_write(1, 5, 32'h22222222);
    set_read(5, 5);
    #1;
    n_cmp++; if (rdata_b[31:0] !== 32'h22222222) begin n_fail++; $display("FAIL collide_bypass: got %h want 22222222", rdata_b[31:0]); end
    n_cmp++; if (rdata_n[63:32] !== exp_read(5, 1'b0)) begin n_fail++; $display("FAIL collide_nobypass: got %h want %h", rdata_n[63:32], exp_read(5, 1'b0)); end
    tick();
    set_idle(); set_read(5, 5);
    #1;
    n_cmp++; if (rdata_b[63:32] !== 32'h22222222) begin n_fail++; $display("FAIL collide_after_b: got %h want 22222222", rdata_b[63:32]); end
    n_cmp++; if (rdata_n[31:0] !== 32'h22222222) begin n_fail++; $display("FAIL collide_after_n: got %h want 22222222", rdata_n[31:0]); end
    $display("txn collision: ports 0/1 -> r5");
  endtask

  task automatic test_no_bypass();
    set_idle(); set_write(0, 7, 32'hA); set_read(0, 0);
    tick();
    set_idle(); set_write(1, 7, 32'hB); set_read(7, 7);
    #1;
    n_cmp++; if (rdata_n[31:0] !== 32'hA) begin n_fail++; $display("FAIL nobypass_same: got %h want 0000000a", rdata_n[31:0]); end
    n_cmp++; if (rdata_b[31:0] !== 32'hB) begin n_fail++; $display("FAIL bypass_same: got %h want 0000000b", rdata_b[31:0]); end
    tick();
    set_idle(); set_read(7, 7);
    #1;
    n_cmp++; if (rdata_n[31:0] !== 32'hB) begin n_fail++; $display("FAIL nobypass_next: got %h want 0000000b", rdata_n[31:0]); end
    $display("txn no_bypass: r7 A -> B");
  endtask

  task automatic test_scoreboard();
    set_idle(); io_alloc_en = 1'b1; io_alloc_addr = 5'd3; set_read(3, 0);
    tick();
    set_idle(); set_read(3, 0);
    #1;
    n_cmp++; if (busy_b[0] !== 1'b1) begin n_fail++; $display("FAIL sb_alloc: got %b want 1", busy_b[0]); end
    set_write(0, 3, 32'h33); io_alloc_en = 1'b1; io_alloc_addr = 5'd3;
    tick();
    set_idle(); set_read(0, 3);
    #1;
    n_cmp++; if (busy_n[1] !== 1'b1) begin n_fail++; $display("FAIL sb_alloc_wins: got %b want 1", busy_n[1]); end
    set_write(1, 3, 32'h44);
    #1;
    // Busy is registered state; a same-cycle write must not hide it.
    n_cmp++; if (busy_b[1] !== 1'b1) begin n_fail++; $display("FAIL sb_not_bypassed: got %b want 1", busy_b[1]); end
    tick();
    set_idle(); set_read(3, 3);
    #1;
    n_cmp++; if (busy_b !== 2'b00) begin n_fail++; $display("FAIL sb_clear: got %b want 00", busy_b); end
    $display("txn scoreboard: alloc/write on r3");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      set_idle(); io_alloc_en = 1'b1; io_alloc_addr = 5'(1 << i);
      tick();
    end
    set_idle(); set_read(2, 4);
    #1;
    n_cmp++; if (busy_b !== 2'b11) begin n_fail++; $display("FAIL flush_pre: got %b want 11", busy_b); end
    io_flush = 1'b1; io_alloc_en = 1'b1; io_alloc_addr = 5'd9;
    tick();
    set_idle();
    for (int r = 0; r < NREG; r++) begin
      set_read(r, r);
      #1;
      n_cmp++; if (busy_b[0] !== m_busy[r]) begin n_fail++; $display("FAIL flush_busy r%0d: got %b want %b", r, busy_b[0], m_busy[r]); end
    end
    $display("txn flush: busy r1,r2,r4 then flush + alloc r9");
  endtask

  task automatic test_random();
    logic [31:0] got;
    for (int t = 0; t < 300; t++) begin
      set_idle();
      io_wen = 2'($urandom_range(0, 3));
      for (int j = 0; j < 2; j++) begin
        io_waddr[j*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        io_wdata[j*XLEN +: XLEN] = $urandom;
      end
      io_alloc_en = ($urandom_range(0, 2) == 0);
      io_alloc_addr = 5'($urandom_range(0, 7));
      io_flush = ($urandom_range(0, 19) == 0);
      set_read($urandom_range(0, 7), $urandom_range(0, 31));
      #1;
      for (int p = 0; p < 2; p++) begin
        got = rdata_b[p*XLEN +: XLEN];
        n_cmp++; if (got !== exp_read(ra[p], 1'b1)) begin n_fail++; $display("FAIL rnd_rdata_b t=%0d p%0d r%0d: got %h want %h", t, p, ra[p], got, exp_read(ra[p], 1'b1)); end
        got = rdata_n[p*XLEN +: XLEN];
        n_cmp++; if (got !== exp_read(ra[p], 1'b0)) begin n_fail++; $display("FAIL rnd_rdata_n t=%0d p%0d r%0d: got %h want %h", t, p, ra[p], got, exp_read(ra[p], 1'b0)); end
        n_cmp++; if (busy_b[p] !== m_busy[ra[p]]) begin n_fail++; $display("FAIL rnd_busy_b t=%0d p%0d r%0d: got %b want %b", t, p, ra[p], busy_b[p], m_busy[ra[p]]); end
        n_cmp++; if (busy_n[p] !== m_busy[ra[p]]) begin n_fail++; $display("FAIL rnd_busy_n t=%0d p%0d r%0d: got %b want %b", t, p, ra[p], busy_n[p], m_busy[ra[p]]); end
      end
      $display("txn rnd %0d: wen=%b waddr=%0d/%0d alloc=%b@%0d flush=%b raddr=%0d/%0d",
               t, io_wen, io_waddr[4:0], io_waddr[9:5], io_alloc_en, io_alloc_addr, io_flush, ra[0], ra[1]);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_collision();
    test_no_bypass();
    test_scoreboard();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
